prbs_checker: RTL
=================

Name: prbs_checker

Overview:
Serial pseudo-random bit-sequence checker that sits directly downstream of the Fibonacci LFSR generator, consuming its serial output bit (previous_msb) after it has crossed the link or loopback under test. It self-synchronises to the incoming stream using the same TAPS polynomial as the generator, then declares lock. While locked it counts received bits and bit errors, and drops lock when the error density exceeds a threshold.

Parameters:
LENGTH, 8, shift-register width; must equal the generator LENGTH.
TAPS, 8'b01110001, feedback taps indexed [0:LENGTH-1], same convention as the generator; bit i=1 means stage i feeds the XOR.
LOCK_COUNT, 16, consecutive correct predictions required to enter LOCKED.
WINDOW, 64, accepted-bit window length for loss-of-lock evaluation.
LOSS_THRESH, 8, errors within one WINDOW that force a return to SEARCH.
CNT_W, 32, width of bit_count and err_count.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  block enable; when low nothing advances.
bit_in  input  1  received serial bit.
bit_valid  input  1  bit_in is valid this cycle; bit accepted when enable && bit_valid.
clear_counts  input  1  synchronous clear of bit_count and err_count.
locked  output  1  high in LOCKED state.
error_pulse  output  1  one-cycle pulse per errored bit while locked.
bit_count  output  CNT_W  bits accepted while locked; saturating.
err_count  output  CNT_W  errored bits while locked; saturating.

Behaviour:
- Reset (rst=1 at a clk edge; applies at any time, including mid-LOCKED): state=SEARCH, shift register r=0, fill_cnt=0, match_cnt=0, window counters=0, locked=0, error_pulse=0, bit_count=0, err_count=0.
- Register r[0:LENGTH-1]. Prediction p = XOR over i of (TAPS[i] & r[i]), computed from r before the shift.
- Every accepted bit shifts r: r[0]<=bit_in, r[i]<=r[i-1]. The received bit is always shifted in, in both states.
- Cycles with no accepted bit: all state holds; error_pulse=0.
- SEARCH:
  - fill_cnt increments per accepted bit, saturating at LENGTH.
  - Once fill_cnt==LENGTH: if bit_in==p and r!=0, match_cnt++; otherwise match_cnt<=0. The all-zero register never counts as a match, so a constant-zero stream never locks.
  - When the accepted bit brings match_cnt to LOCK_COUNT, state<=LOCKED. locked is registered and goes high on that same edge. Window counters are cleared on entry.
  - bit_count, err_count and error_pulse do not change in SEARCH.
- LOCKED:
  - Per accepted bit: bit_count++ (saturating at all-ones).
  - If bit_in!=p: err_count++ (saturating), error_pulse=1 on the following cycle (registered, 1-cycle latency), and win_err++.
  - win_bits counts accepted bits. When win_err reaches LOSS_THRESH: state<=SEARCH, locked<=0, fill_cnt<=0, match_cnt<=0 on that edge. Counts are held, not cleared.
  - When win_bits reaches WINDOW without loss: win_bits<=0 and win_err<=0.
- Error multiplication: because received bits are shifted in, one flipped line bit yields 1+popcount(TAPS) errors (5 with default TAPS).
- clear_counts: bit_count<=0 and err_count<=0. It takes priority over an increment in the same cycle, so that bit is not counted. error_pulse is still generated. clear_counts does not affect state or lock.
- rst has priority over clear_counts and enable.

Test Plan:
1. Reset, then connect to an 8-bit generator (TAPS 8'b01110001, seed 1, enabled) with bit_valid=1 -> locked rises exactly at the edge of the 24th accepted bit (LENGTH+LOCK_COUNT); after 1000 further bits, bit_count=1000, err_count=0, no error_pulse.
2. While locked, invert one bit -> exactly 5 error_pulse cycles within the next 8 bits; err_count=5; locked stays 1.
3. Drive bit_in=0 for 200 accepted bits after reset -> locked never asserts; counts stay 0.
4. While locked, switch to random bits -> locked falls within 64 bits once win_err=8. Restoring the clean stream -> locked reasserts after 24 clean bits, and err_count is held across the relock.
5. Assert clear_counts in the same cycle as an errored bit -> next cycle bit_count=0, err_count=0, error_pulse=1; the following clean bit gives bit_count=1.
6. Toggle bit_valid 1/0 and hold enable=0 for 10 cycles -> no counter or state change on unaccepted cycles. Assert rst while locked -> next edge locked=0 and all counts 0.

Source files
------------

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: stream, control and status signals of the PRBS checker
interface prbs_checker_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             bit_in;
    logic             bit_valid;
    logic             clear_counts;
    logic             locked;
    logic             error_pulse;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, bit_in, bit_valid, clear_counts,
        input  locked, error_pulse, bit_count, err_count
    );

    modport slave (
        input  enable, bit_in, bit_valid, clear_counts,
        output locked, error_pulse, bit_count, err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker with lock detection and error counting
module prbs_checker #(
    parameter int                  LENGTH      = 8,
    parameter logic [0:LENGTH-1]   TAPS        = 8'b01110001,
    parameter int                  LOCK_COUNT  = 16,
    parameter int                  WINDOW      = 64,
    parameter int                  LOSS_THRESH = 8,
    parameter int                  CNT_W       = 32
) (
    input logic          clk,
    input logic          rst,
    prbs_checker_if.slave bus
);
    localparam int FW  = $clog2(LENGTH + 1);
    localparam int MW  = $clog2(LOCK_COUNT + 1);
    localparam int WBW = $clog2(WINDOW + 1);
    localparam int WEW = $clog2(LOSS_THRESH + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state;
    logic [0:LENGTH-1] r;
    logic [FW-1:0]     fill_cnt;
    logic [MW-1:0]     match_cnt;
    logic [WBW-1:0]    win_bits;
    logic [WEW-1:0]    win_err;
    logic              locked;
    logic              error_pulse;
    logic [CNT_W-1:0]  bit_count;
    logic [CNT_W-1:0]  err_count;
    logic              p;
    logic              acc;
    logic              err;

    // Predicted bit from the register before the shift, and whether the incoming bit disagrees
    always_comb begin
        p   = ^(TAPS & r);
        acc = bus.enable & bus.bit_valid;
        err = bus.bit_in ^ p;
    end

    // Search/lock state machine, shift register, window tracking and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            r           <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_bits    <= '0;
            win_err     <= '0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            bit_count   <= '0;
            err_count   <= '0;
        end else begin
            error_pulse <= 1'b0;
            if (acc) begin
                r <= {bus.bit_in, r[0:LENGTH-2]};
                if (state == SEARCH) begin
                    if (fill_cnt != FW'(LENGTH)) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end else if (!err && r != '0) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            win_bits <= '0;
                            win_err  <= '0;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    if (bit_count != '1) bit_count <= bit_count + 1'b1;
                    if (err) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        error_pulse <= 1'b1;
                    end
                    if (win_err + WEW'(err) == WEW'(LOSS_THRESH)) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                    end else if (win_bits == WBW'(WINDOW - 1)) begin
                        win_bits <= '0;
                        win_err  <= '0;
                    end else begin
                        win_bits <= win_bits + 1'b1;
                        win_err  <= win_err + WEW'(err);
                    end
                end
            end
            if (bus.clear_counts) begin
                bit_count <= '0;
                err_count <= '0;
            end
        end
    end

    assign bus.locked      = locked;
    assign bus.error_pulse = error_pulse;
    assign bus.bit_count   = bit_count;
    assign bus.err_count   = err_count;
endmodule
